// File: rtl/slt_serial_pkg.sv
// Shared types for the bit-serial signed/unsigned comparator.
package slt_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } slt_serial_state_t;

endpackage

// File: rtl/slt_serial_full_adder.sv
// One-bit full adder used as the serial subtractor core of slt_serial.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/slt_serial.sv
// Bit-serial comparator: forms a + ~b + 1 LSB-first, one bit per clock,
// and reports signed/unsigned less-than and equality.
//
// state  | meaning
// S_IDLE | ready for operands, i_ready=1
// S_BUSY | shifting one operand bit per clock through the adder
// S_DONE | results presented, o_valid=1 until o_ready
module slt_serial
    import slt_serial_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         lt,
    output logic         ltu,
    output logic         eq
);

    localparam int CW = $clog2(N);

    slt_serial_state_t state, state_next;

    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [CW-1:0] count;
    logic          carry;
    logic          eq_acc;
    logic          nb;
    logic          s;
    logic          c_next;
    logic          last;
    logic          bit_eq;

    assign nb     = ~b_sr[0];
    assign last   = (count == CW'(N - 1));
    assign bit_eq = (a_sr[0] == b_sr[0]);

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (nb),
        .c_in  (carry),
        .sum   (s),
        .c_out (c_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        i_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_next = S_BUSY;
            end
            S_BUSY: begin
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (o_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            count  <= '0;
            carry  <= 1'b0;
            eq_acc <= 1'b0;
            lt     <= 1'b0;
            ltu    <= 1'b0;
            eq     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= 1'b1;
                        eq_acc <= 1'b1;
                        count  <= '0;
                    end
                end
                S_BUSY: begin
                    carry  <= c_next;
                    eq_acc <= eq_acc & bit_eq;
                    a_sr   <= {1'b0, a_sr[N-1:1]};
                    b_sr   <= {1'b0, b_sr[N-1:1]};
                    if (last) begin
                        count <= '0;
                        ltu   <= ~c_next;
                        // differing sign bits decide lt directly, immune to overflow
                        lt    <= (a_sr[0] ^ b_sr[0]) ? a_sr[0] : s;
                        eq    <= eq_acc & bit_eq;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slt_serial.sv
// Self-checking bench for slt_serial at N=32 and N=4 against a high-level compare model.
module tb_slt_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv32, ir32, ov32, or32, lt32, ltu32, eq32;
    logic [31:0] a32, b32;
    logic        iv4, ir4, ov4, or4, lt4, ltu4, eq4;
    logic [3:0]  a4, b4;

    slt_serial #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .i_valid(iv32), .i_ready(ir32), .a(a32), .b(b32),
        .o_valid(ov32), .o_ready(or32), .lt(lt32), .ltu(ltu32), .eq(eq32)
    );

    slt_serial #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(iv4), .i_ready(ir4), .a(a4), .b(b4),
        .o_valid(ov4), .o_ready(or4), .lt(lt4), .ltu(ltu4), .eq(eq4)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        lt;
        logic        ltu;
        logic        eq;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [2:0] model32(input logic [31:0] x, input logic [31:0] y);
        return {($signed(x) < $signed(y)), (x < y), (x == y)};
    endfunction

    function automatic logic [2:0] model4(input logic [3:0] x, input logic [3:0] y);
        return {($signed(x) < $signed(y)), (x < y), (x == y)};
    endfunction

    // Starts an op at a negedge in IDLE; returns at the negedge where o_valid is seen.
    task automatic op32(input logic [31:0] x, input logic [31:0] y, output int lat, output logic busy_ok);
        a32  = x;
        b32  = y;
        iv32 = 1'b1;
        @(negedge clk);
        iv32    = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!ov32 && lat < 100) begin
            if (ir32 !== 1'b0) busy_ok = 1'b0;
            a32 = $urandom;
            b32 = $urandom;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain32();
        or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
        check("drain_o_valid", ov32, 0);
        check("drain_i_ready", ir32, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        busy_ok;
        logic [2:0]  exp;
        logic [31:0] ra, rb;

        vecs[0] = '{32'd5,          32'd7,          1'b1, 1'b1, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h0,          32'h0,          1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'd3,          32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
        iv4  = 1'b0; or4  = 1'b0; a4  = '0; b4  = '0;
        repeat (2) @(negedge clk);
        check("reset_i_ready", ir32, 1);
        check("reset_o_valid", ov32, 0);
        check("reset_outputs", {lt32, ltu32, eq32}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            op32(vecs[i].a, vecs[i].b, lat, busy_ok);
            check($sformatf("vec%0d_latency", i), lat, 32);
            check($sformatf("vec%0d_busy_i_ready", i), busy_ok, 1);
            check($sformatf("vec%0d_lt", i), lt32, vecs[i].lt);
            check($sformatf("vec%0d_ltu", i), ltu32, vecs[i].ltu);
            check($sformatf("vec%0d_eq", i), eq32, vecs[i].eq);
            drain32();
        end

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            if (i % 7 == 3) rb = ra ^ 32'h8000_0000;
            exp = model32(ra, rb);
            op32(ra, rb, lat, busy_ok);
            check("rand_latency", lat, 32);
            check("rand_result", {lt32, ltu32, eq32}, exp);
            drain32();
        end

        // Backpressure: results held, new operands ignored while stalled.
        op32(32'h10, 32'h20, lat, busy_ok);
        for (int i = 0; i < 5; i++) begin
            check("bp_o_valid", ov32, 1);
            check("bp_i_ready", ir32, 0);
            check("bp_result", {lt32, ltu32, eq32}, 3'b110);
            if (i == 2) begin
                a32  = 32'h0;
                b32  = 32'h0;
                iv32 = 1'b1;
            end
            @(negedge clk);
            iv32 = 1'b0;
        end
        drain32();
        @(negedge clk);
        check("bp_pulse_ignored", ir32, 1);
        check("bp_result_kept", {lt32, ltu32, eq32}, 3'b110);

        // Reset on the 10th busy edge of an operation whose results would be nonzero.
        a32  = 32'd5;
        b32  = 32'd7;
        iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_i_ready", ir32, 1);
        check("midrst_o_valid", ov32, 0);
        check("midrst_outputs", {lt32, ltu32, eq32}, 3'b000);
        op32(32'd3, 32'hFFFF_FFFC, lat, busy_ok);
        check("postrst_latency", lat, 32);
        check("postrst_result", {lt32, ltu32, eq32}, 3'b010);
        drain32();

        // Exhaustive N=4, back-to-back with random output stalls.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a4  = 4'(x);
                b4  = 4'(y);
                iv4 = 1'b1;
                @(negedge clk);
                iv4 = 1'b0;
                lat = 0;
                while (!ov4 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                check("n4_latency", lat, 4);
                check($sformatf("n4_result a=%0d b=%0d", x, y), {lt4, ltu4, eq4}, model4(4'(x), 4'(y)));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                or4 = 1'b1;
                @(negedge clk);
                or4 = 1'b0;
                if (ir4 !== 1'b1) check("n4_ready_after_drain", ir4, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/slt_serial.md
Name: slt_serial

Overview:
- Multi-cycle, bit-serial signed/unsigned comparator; LSB-first, one bit per clock.
- Computes a + ~b + 1 through a single 1-bit full adder with a registered carry.
- Reports lt (signed), ltu (unsigned) and eq, with valid/ready handshakes on input and output.
- Area-cheap counterpart to the combinational N-bit comparator, for datapaths that can tolerate N-cycle latency.

Parameters:
- N, 32, operand width in bits; legal range N >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- i_valid  input  1  operands a/b are valid.
- i_ready  output  1  block can accept operands; high only in S_IDLE.
- a  input  N  operand A, two's complement for lt.
- b  input  N  operand B, two's complement for lt.
- o_valid  output  1  results valid; high only in S_DONE.
- o_ready  input  1  consumer accepts results.
- lt  output  1  signed a < b.
- ltu  output  1  unsigned a < b.
- eq  output  1  a == b.

Behaviour:
- States: S_IDLE, S_BUSY, S_DONE.
- Reset (rst=1 at an edge), from any state including mid-operation:
  - state -> S_IDLE; shift registers, count, carry cleared.
  - lt=0, ltu=0, eq=0, o_valid=0, i_ready=1 after that edge.
  - Any in-flight operation is discarded.
- S_IDLE:
  - i_ready=1.
  - On an edge with i_valid=1: latch a, b into N-bit shift registers; carry<=1 (the +1 of negation); eq_acc<=1; count<=0; go to S_BUSY.
  - i_valid=0: stay.
- S_BUSY (i_ready=0, o_valid=0), each edge:
  - s = a_sr[0] ^ ~b_sr[0] ^ carry.
  - carry <= majority(a_sr[0], ~b_sr[0], carry).
  - eq_acc <= eq_acc & (a_sr[0] == b_sr[0]).
  - Shift both registers right by 1; count <= count + 1.
  - When count == N-1 (last bit = sign bit), additionally capture:
    - sa = a_sr[0], sb = b_sr[0], smsb = s, cout = new carry.
    - Go to S_DONE.
- Result equations (registered on the same edge that enters S_DONE):
  - ltu = ~cout.
  - lt = (sa ^ sb) ? sa : smsb. The sign-mismatch override makes lt correct on subtraction overflow.
  - eq = final eq_acc.
- Latency: o_valid rises exactly N edges after the accepting edge.
- S_DONE:
  - o_valid=1; lt/ltu/eq held stable while o_ready=0.
  - On an edge with o_ready=1: go to S_IDLE; o_valid drops; lt/ltu/eq keep their values (don't-care when o_valid=0).
- Throughput: no overlap between operations. Minimum period is N+2 cycles (accept, N busy edges, drain).
- i_valid while i_ready=0 is ignored. Operands are not sampled outside the accepting edge, so a/b may change freely during S_BUSY.
- count width is $clog2(N); count never wraps past N-1.
- Simultaneous rst and a handshake: rst wins.

Decomposition:
- Package slt_serial_pkg: enum slt_serial_state_t {S_IDLE, S_BUSY, S_DONE}.
- Sub-module full_adder (1-bit: a, b, c_in -> sum, c_out), instantiated once for the serial adder.
- All else inline.

Test Plan:
- Basic: N=32, a=5, b=7 -> lt=1, ltu=1, eq=0; o_valid exactly 32 edges after accept; i_ready=0 throughout.
- Overflow: a=32'h80000000, b=32'h7FFFFFFF -> lt=1, ltu=0, eq=0. Swap a/b -> lt=0, ltu=1.
- Equality: a=b=32'hFFFFFFFF -> lt=0, ltu=0, eq=1. Also a=b=0 -> eq=1, lt=0, ltu=0.
- Backpressure: hold o_ready=0 for 5 cycles after o_valid -> lt/ltu/eq/o_valid stable, i_ready=0, pulsed i_valid with new operands ignored. o_ready=1 -> next cycle o_valid=0, i_ready=1.
- Reset mid-op: rst=1 on the 10th S_BUSY edge -> next cycle i_ready=1, o_valid=0, outputs 0. Then a=3, b=32'hFFFFFFFC -> lt=0, ltu=1, eq=0.
- Exhaustive: N=4, all 256 (a,b) pairs, back-to-back with random o_ready stalls -> lt == ($signed(a) < $signed(b)), ltu == (a < b), eq == (a == b).
